// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: shared definitions for the ALU scheduler.
//   - opcode constants understood by the ALU (OP_CLR..OP_SHR)
//   - scheduler FSM state type
//   - bit positions inside the 4-bit ALU flag vector {mr_en, ovf, zero, neg}
package alu_sched_pkg;

  localparam logic [3:0] OP_CLR = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_MPY = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd6;
  localparam logic [3:0] OP_NOT = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam int unsigned FLAG_NEG   = 0;
  localparam int unsigned FLAG_ZERO  = 1;
  localparam int unsigned FLAG_OVF   = 2;
  localparam int unsigned FLAG_MR_EN = 3;

  function automatic logic op_legal(input logic [3:0] op);
    return (op >= OP_CLR) && (op <= OP_SHR);
  endfunction

endpackage

// File: rtl/alu_sched_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
//   clk, rst  : clock, asynchronous active-high reset
//   req[1:0]  : request lines
//   advance   : a grant was consumed this cycle; move the pointer
//   grant[1:0]: one-hot (or zero) combinational grant
// The pointer names the preferred requester; after each consumed grant it
// points at the requester that did not win.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr;

  always_comb begin
    grant = '0;
    if (req[ptr]) begin
      grant[ptr] = 1'b1;
    end else if (req[~ptr]) begin
      grant[~ptr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (advance && (grant != '0)) begin
      ptr <= ~grant[1];
    end
  end

endmodule

// File: rtl/alu_sched.sv
// alu_sched: serialises ALU operations from two requesters (0 = CU, 1 = aux)
// onto a single ALU with fixed latency ALU_LAT; one operation in flight.
//   req_valid/req_ready  : per-requester request handshake (req_ready comb.)
//   req_op*/req_a*/req_b*: opcode and operands of each requester
//   alu_ctrl/alu_a/alu_b : ALU control word (opcode in [15:12]) and operands
//   alu_res/alu_mr/flags : ALU outputs, sampled ALU_LAT cycles after issue
//   rsp_valid/rsp_ready  : per-requester response handshake
//   rsp_data/mr/flags/err: shared response payload, qualified by rsp_valid
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int unsigned W       = 16,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [3:0]   req_op0,
  input  logic [3:0]   req_op1,
  input  logic [W-1:0] req_a0,
  input  logic [W-1:0] req_b0,
  input  logic [W-1:0] req_a1,
  input  logic [W-1:0] req_b1,
  output logic [15:0]  alu_ctrl,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_res,
  input  logic [W-1:0] alu_mr,
  input  logic [3:0]   alu_flags,
  output logic [1:0]   rsp_valid,
  input  logic [1:0]   rsp_ready,
  output logic [W-1:0] rsp_data,
  output logic [W-1:0] rsp_mr,
  output logic [3:0]   rsp_flags,
  output logic         rsp_err
);

  localparam int unsigned CW = 3;

  state_t         state, state_nxt;
  logic [1:0]     gnt;
  logic           accept;
  logic           id_q;
  logic [CW-1:0]  cnt;
  logic [3:0]     sel_op;
  logic [W-1:0]   sel_a, sel_b;
  logic           last_cnt;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (accept),
    .grant   (gnt)
  );

  assign accept    = (state == ST_IDLE) && (gnt != '0) && !rst;
  assign req_ready = accept ? gnt : '0;
  assign sel_op    = gnt[1] ? req_op1 : req_op0;
  assign sel_a     = gnt[1] ? req_a1  : req_a0;
  assign sel_b     = gnt[1] ? req_b1  : req_b0;
  assign last_cnt  = (cnt == CW'(ALU_LAT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = op_legal(sel_op) ? ST_ISSUE : ST_RESP;
        end
      end
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (last_cnt) begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready[id_q]) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The granted opcode goes straight into alu_ctrl on accept, so the control
  // word itself is the op latch; it is cleared after the single ISSUE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_q      <= 1'b0;
      cnt       <= '0;
      alu_ctrl  <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_mr    <= '0;
      rsp_flags <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            id_q <= gnt[1];
            if (op_legal(sel_op)) begin
              alu_ctrl <= {sel_op, 12'h000};
              alu_a    <= sel_a;
              alu_b    <= sel_b;
            end else begin
              rsp_valid <= gnt;
              rsp_data  <= '0;
              rsp_mr    <= '0;
              rsp_flags <= '0;
              rsp_err   <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          alu_ctrl <= '0;
          cnt      <= CW'(1);
        end
        ST_WAIT: begin
          if (last_cnt) begin
            cnt       <= '0;
            rsp_valid <= id_q ? 2'b10 : 2'b01;
            rsp_data  <= alu_res;
            rsp_mr    <= alu_mr;
            rsp_flags <= alu_flags;
            rsp_err   <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready[id_q]) begin
            rsp_valid <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
module tb_alu_sched;
  import alu_sched_pkg::*;

  localparam int unsigned W   = 16;
  localparam int unsigned LAT = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req_valid, req_ready;
  logic [3:0]   req_op0, req_op1;
  logic [W-1:0] req_a0, req_b0, req_a1, req_b1;
  logic [15:0]  alu_ctrl;
  logic [W-1:0] alu_a, alu_b, alu_res, alu_mr;
  logic [3:0]   alu_flags;
  logic [1:0]   rsp_valid, rsp_ready;
  logic [W-1:0] rsp_data, rsp_mr;
  logic [3:0]   rsp_flags;
  logic         rsp_err;

  alu_sched #(.W(W), .ALU_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
    .alu_res(alu_res), .alu_mr(alu_mr), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_mr(rsp_mr), .rsp_flags(rsp_flags), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference ALU ----------------
  typedef struct packed {
    logic [W-1:0] res;
    logic [W-1:0] mr;
    logic [3:0]   flags;
  } alu_out_t;

  function automatic alu_out_t alu_model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    alu_out_t o;
    logic [2*W-1:0] p;
    logic [W:0] s;
    logic ovf, mren;
    o = '0; ovf = 1'b0; mren = 1'b0;
    case (op)
      4'd2: begin s = {1'b0, a} + {1'b0, b}; o.res = s[W-1:0]; ovf = s[W]; end
      4'd3: begin s = {1'b0, a} - {1'b0, b}; o.res = s[W-1:0]; ovf = s[W]; end
      4'd4: begin p = a * b; o.res = p[W-1:0]; o.mr = p[2*W-1:W]; mren = 1'b1; end
      4'd5: o.res = a & b;
      4'd6: o.res = a | b;
      4'd7: o.res = ~a;
      4'd8: o.res = a << 1;
      4'd9: o.res = a >> 1;
      default: o.res = '0;
    endcase
    o.flags = {mren, ovf, (o.res == '0), o.res[W-1]};
    return o;
  endfunction

  // Bench ALU: remembers the opcode of the last issue pulse, output follows held operands.
  logic [3:0] cur_op = 4'd0;
  alu_out_t   alu_o;
  always @(posedge clk) if (alu_ctrl[15:12] != 4'd0) cur_op <= alu_ctrl[15:12];
  always_comb alu_o = alu_model(cur_op, alu_a, alu_b);
  assign alu_res   = alu_o.res;
  assign alu_mr    = alu_o.mr;
  assign alu_flags = alu_o.flags;

  // ---------------- scoreboard + grant monitor ----------------
  typedef struct packed {
    logic         id;
    logic [W-1:0] d;
    logic [W-1:0] mr;
    logic [3:0]   fl;
    logic         err;
  } exp_t;

  exp_t sb[$];
  logic glog[$];
  logic mptr = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    alu_out_t m;
    logic gid, egid;
    logic [3:0] op;
    if (rst) begin
      sb.delete();
      mptr = 1'b0;
    end else begin
      if (alu_ctrl != 16'h0) chk(alu_ctrl[11:0] == 12'h0, "ctrl_low_bits", alu_ctrl, {alu_ctrl[15:12], 12'h0});
      if ((rsp_valid & rsp_ready) != 2'b00) begin
        chk(sb.size() != 0, "sb_unexpected_rsp", rsp_valid, 0);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk(rsp_valid == (e.id ? 2'b10 : 2'b01), "sb_rsp_valid", rsp_valid, e.id ? 2'b10 : 2'b01);
          chk(rsp_data == e.d, "sb_rsp_data", rsp_data, e.d);
          chk(rsp_mr == e.mr, "sb_rsp_mr", rsp_mr, e.mr);
          chk(rsp_flags == e.fl, "sb_rsp_flags", rsp_flags, e.fl);
          chk(rsp_err == e.err, "sb_rsp_err", rsp_err, e.err);
        end
      end
      if (req_ready != 2'b00) begin
        gid  = req_ready[1];
        egid = (req_valid == 2'b11) ? mptr : req_valid[1];
        chk(req_ready != 2'b11, "grant_onehot", req_ready, 2'b01);
        chk(gid == egid, "rr_grant", gid, egid);
        mptr = ~gid;
        glog.push_back(gid);
        op = gid ? req_op1 : req_op0;
        e.id = gid;
        if (op >= 4'd1 && op <= 4'd9) begin
          m = alu_model(op, gid ? req_a1 : req_a0, gid ? req_b1 : req_b0);
          e.d = m.res; e.mr = m.mr; e.fl = m.flags; e.err = 1'b0;
        end else begin
          e.d = '0; e.mr = '0; e.fl = '0; e.err = 1'b1;
        end
        sb.push_back(e);
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic         id;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic [W-1:0] mr;
    logic         err;
  } vec_t;

  vec_t vt[12];

  task automatic drive_req(input logic id, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    if (id) begin req_op1 = op; req_a1 = a; req_b1 = b; end
    else    begin req_op0 = op; req_a0 = a; req_b0 = b; end
    req_valid[id] = 1'b1;
  endtask

  task automatic outs_zero(input string tag);
    chk(req_ready == 2'b00, {tag, "_req_ready"}, req_ready, 0);
    chk(rsp_valid == 2'b00, {tag, "_rsp_valid"}, rsp_valid, 0);
    chk(alu_ctrl == 16'h0, {tag, "_alu_ctrl"}, alu_ctrl, 0);
    chk(alu_a == '0 && alu_b == '0, {tag, "_alu_ab"}, {alu_a, alu_b}, 0);
    chk(rsp_data == '0 && rsp_mr == '0, {tag, "_rsp_dm"}, {rsp_data, rsp_mr}, 0);
    chk(rsp_flags == 4'h0 && !rsp_err, {tag, "_rsp_fe"}, {rsp_flags, rsp_err}, 0);
  endtask

  // One complete transaction from an idle scheduler, with timing checks.
  task automatic txn(input int k);
    int acc, rc, pulses, wait_n;
    logic [15:0] ctrlv;
    logic [W-1:0] cd, cm;
    logic [3:0] cf;
    logic ce;
    vec_t v;
    v = vt[k];
    acc = -1; rc = -1; pulses = 0; ctrlv = 16'h0; wait_n = 0;
    cd = '0; cm = '0; cf = '0; ce = 1'b0;
    @(posedge clk); #1;
    rsp_ready = 2'b11;
    drive_req(v.id, v.op, v.a, v.b);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready[v.id]) begin acc = cyc; break; end
      wait_n++;
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    chk(acc >= 0, "accept_timeout", k, 0);
    if (acc < 0) return;
    chk(wait_n == 0, "accept_first_cycle", wait_n, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (alu_ctrl != 16'h0) begin pulses++; ctrlv = alu_ctrl; end
      if (rsp_valid[v.id]) begin
        rc = cyc; cd = rsp_data; cm = rsp_mr; cf = rsp_flags; ce = rsp_err;
        break;
      end
    end
    chk(rc >= 0, "rsp_timeout", k, 0);
    if (rc < 0) return;
    chk(rc - acc == (v.err ? 1 : 2 + LAT), "rsp_latency", rc - acc, v.err ? 1 : 2 + LAT);
    chk(pulses == (v.err ? 0 : 1), "ctrl_pulse_count", pulses, v.err ? 0 : 1);
    if (!v.err) chk(ctrlv == {v.op, 12'h000}, "ctrl_word", ctrlv, {v.op, 12'h000});
    chk(cd == v.d, "vec_data", cd, v.d);
    chk(cm == v.mr, "vec_mr", cm, v.mr);
    chk(ce == v.err, "vec_err", ce, v.err);
    if (v.op == OP_MPY) chk(cf[FLAG_MR_EN] == 1'b1, "mpy_mr_en", cf, 4'h8);
    @(posedge clk);
  endtask

  task automatic wait_ready(input logic id, input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req_ready[id]) begin got = 1'b1; break; end
    end
    chk(got, name, req_ready, {1'b0, 1'b1} << id);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    bit got;
    logic [W-1:0] d0;

    vt[0]  = '{1'b0, 4'd2, 16'h0003, 16'h0004, 16'h0007, 16'h0000, 1'b0};
    vt[1]  = '{1'b1, 4'd4, 16'h0100, 16'h0100, 16'h0000, 16'h0001, 1'b0};
    vt[2]  = '{1'b0, 4'd3, 16'h0005, 16'h0007, 16'hFFFE, 16'h0000, 1'b0};
    vt[3]  = '{1'b1, 4'd5, 16'hF0F0, 16'hFF00, 16'hF000, 16'h0000, 1'b0};
    vt[4]  = '{1'b0, 4'd6, 16'h0F00, 16'h00F0, 16'h0FF0, 16'h0000, 1'b0};
    vt[5]  = '{1'b1, 4'd7, 16'h1234, 16'h0000, 16'hEDCB, 16'h0000, 1'b0};
    vt[6]  = '{1'b0, 4'd8, 16'h8001, 16'h0000, 16'h0002, 16'h0000, 1'b0};
    vt[7]  = '{1'b1, 4'd9, 16'h8001, 16'h0000, 16'h4000, 16'h0000, 1'b0};
    vt[8]  = '{1'b0, 4'd1, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 1'b0};
    vt[9]  = '{1'b0, 4'hC, 16'h1111, 16'h2222, 16'h0000, 16'h0000, 1'b1};
    vt[10] = '{1'b1, 4'h0, 16'h1111, 16'h2222, 16'h0000, 16'h0000, 1'b1};
    vt[11] = '{1'b0, 4'hF, 16'hAAAA, 16'h5555, 16'h0000, 16'h0000, 1'b1};

    rst = 1'b1;
    req_valid = 2'b00; rsp_ready = 2'b00;
    req_op0 = 4'd0; req_op1 = 4'd0;
    req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
    repeat (3) @(posedge clk);
    #1;
    outs_zero("reset");
    rst = 1'b0;

    for (int k = 0; k < 12; k++) txn(k);

    // Both requesters continuously valid: grants must alternate.
    @(posedge clk); #1;
    rsp_ready = 2'b11;
    drive_req(1'b0, OP_ADD, 16'h0001, 16'h0002);
    drive_req(1'b1, OP_ADD, 16'h0010, 16'h0020);
    n0 = glog.size();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (glog.size() >= n0 + 6) break;
    end
    chk(glog.size() >= n0 + 6, "alt_grant_count", glog.size() - n0, 6);
    @(posedge clk); #1;
    req_valid = 2'b00;
    for (int i = n0 + 1; i < n0 + 6 && i < glog.size(); i++)
      chk(glog[i] != glog[i-1], "alt_order", glog[i], ~glog[i-1]);
    repeat (12) @(posedge clk);

    // Response back-pressure: requester 0 stalls, requester 1 must wait.
    #1;
    rsp_ready = 2'b00;
    drive_req(1'b0, OP_ADD, 16'h0010, 16'h0020);
    wait_ready(1'b0, "stall_accept");
    @(posedge clk); #1;
    req_valid = 2'b00;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid[0]) begin got = 1'b1; break; end
    end
    chk(got, "stall_rsp_timeout", rsp_valid, 2'b01);
    d0 = rsp_data;
    chk(d0 == 16'h0030, "stall_data", d0, 16'h0030);
    @(posedge clk); #1;
    drive_req(1'b1, OP_OR, 16'h00F0, 16'h000F);
    rsp_ready = 2'b10;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk(rsp_valid == 2'b01, "stall_valid_hold", rsp_valid, 2'b01);
      chk(rsp_data == d0, "stall_data_hold", rsp_data, d0);
      chk(req_ready == 2'b00, "stall_no_accept", req_ready, 0);
    end
    @(posedge clk); #1;
    rsp_ready = 2'b11;
    wait_ready(1'b1, "stall_loser_granted");
    @(posedge clk); #1;
    req_valid = 2'b00;
    repeat (12) @(posedge clk);

    // Reset pulse while the operation is in WAIT.
    #1;
    drive_req(1'b0, OP_ADD, 16'h0001, 16'h0001);
    wait_ready(1'b0, "rstw_accept");
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(posedge clk); #1;
    rst = 1'b1;
    drive_req(1'b1, OP_ADD, 16'h0002, 16'h0002);
    #1;
    outs_zero("rst_wait");
    @(posedge clk); #1;
    outs_zero("rst_held");
    req_valid = 2'b00;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk(rsp_valid == 2'b00, "rst_no_rsp", rsp_valid, 0);
    end
    txn(0);
    txn(1);

    repeat (4) @(posedge clk);
    chk(sb.size() == 0, "sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
